// File: rtl/card_dealer_pkg.sv
// Shared deck constants, FSM state encoding and index helpers
// for the card dealer and the display path.
package card_dealer_pkg;

   localparam int DECK_SIZE = 52;
   localparam int NUM_RANKS = 13;

   localparam logic [3:0] RANK_A  = 4'd1;
   localparam logic [3:0] RANK_10 = 4'd10;
   localparam logic [3:0] RANK_K  = 4'd13;

   localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_CHECK,
      ST_SCAN,
      ST_DEAL
   } state_t;

   function automatic logic [5:0] next_idx(input logic [5:0] i);
      return (i == LAST_IDX) ? 6'd0 : i + 6'd1;
   endfunction

endpackage

// File: rtl/card_dealer_decode.sv
// Card index 0..51 to suit, rank and blackjack value.
// Purely combinational; shared with the HEX display path.
module card_dealer_decode
   import card_dealer_pkg::*;
(
   input  logic [5:0] idx,
   output logic [1:0] suit,
   output logic [3:0] rank,
   output logic [3:0] value
);

   localparam logic [5:0] R1 = 6'(NUM_RANKS);
   localparam logic [5:0] R2 = 6'(2 * NUM_RANKS);
   localparam logic [5:0] R3 = 6'(3 * NUM_RANKS);

   logic [5:0] off;

   always_comb begin
      suit = 2'd0;
      off  = idx;
      unique case (1'b1)
         (idx < R1): begin
            suit = 2'd0;
            off  = idx;
         end
         (idx >= R1 && idx < R2): begin
            suit = 2'd1;
            off  = idx - R1;
         end
         (idx >= R2 && idx < R3): begin
            suit = 2'd2;
            off  = idx - R2;
         end
         (idx >= R3): begin
            suit = 2'd3;
            off  = idx - R3;
         end
      endcase
      rank  = 4'(off + 6'(RANK_A));
      value = (rank >= RANK_10) ? RANK_10 : rank;
   end

endmodule

// File: rtl/card_dealer.sv
// Deals unique cards from a 52-card deck using draws from the RNG,
// falling back to a linear scan after repeated rejected draws.
module card_dealer
   import card_dealer_pkg::*;
#(
   parameter int MAX_TRIES = 8,
   parameter int RNG_W     = 6
)
(
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             deal_req,
   input  logic             shuffle,
   output logic             rng_req,
   input  logic             rng_valid,
   input  logic [RNG_W-1:0] rng_data,
   output logic             card_valid,
   output logic [1:0]       card_suit,
   output logic [3:0]       card_rank,
   output logic [3:0]       card_value,
   output logic [5:0]       cards_left,
   output logic             deck_empty,
   output logic             busy,
   output logic             deal_err
);

   localparam logic [RNG_W-1:0] DECK_W = RNG_W'(DECK_SIZE);
   localparam logic [3:0]       LAST_TRY = 4'(MAX_TRIES - 1);

   state_t           state;
   logic [DECK_SIZE-1:0] used;
   logic [RNG_W-1:0] rng_q;
   logic [RNG_W-1:0] folded;
   logic [5:0]       idx_q;
   logic [5:0]       chk_idx;
   logic [5:0]       sel_idx;
   logic [3:0]       tries;
   logic             chk_ok;
   logic             scan_ok;
   logic             take;
   logic [1:0]       dec_suit;
   logic [3:0]       dec_rank;
   logic [3:0]       dec_value;

   // Wide RNGs can fold past the deck; such draws are rejected anyway.
   always_comb begin
      folded  = (rng_q >= DECK_W) ? rng_q - DECK_W : rng_q;
      chk_idx = (folded >= DECK_W) ? 6'd0 : 6'(folded);
      chk_ok  = (rng_q < DECK_W) && !used[chk_idx];
      scan_ok = !used[idx_q];
      take    = ((state == ST_CHECK) && chk_ok) ||
                ((state == ST_SCAN) && scan_ok);
      sel_idx = (state == ST_SCAN) ? idx_q : chk_idx;
   end

   card_dealer_decode u_decode (
      .idx   (sel_idx),
      .suit  (dec_suit),
      .rank  (dec_rank),
      .value (dec_value)
   );

   assign deck_empty = (cards_left == 6'd0);
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         used       <= '0;
         rng_q      <= '0;
         idx_q      <= '0;
         tries      <= '0;
         rng_req    <= 1'b0;
         card_valid <= 1'b0;
         card_suit  <= '0;
         card_rank  <= '0;
         card_value <= '0;
         cards_left <= 6'(DECK_SIZE);
         deal_err   <= 1'b0;
      end else if (shuffle) begin
         state      <= ST_IDLE;
         used       <= '0;
         tries      <= '0;
         rng_req    <= 1'b0;
         card_valid <= 1'b0;
         card_suit  <= '0;
         card_rank  <= '0;
         card_value <= '0;
         cards_left <= 6'(DECK_SIZE);
         deal_err   <= 1'b0;
      end else begin
         card_valid <= 1'b0;
         deal_err   <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (deal_req && deck_empty) begin
                  deal_err <= 1'b1;
               end else if (deal_req) begin
                  state   <= ST_REQ;
                  rng_req <= 1'b1;
                  tries   <= '0;
               end
            end
            ST_REQ: begin
               if (rng_valid) begin
                  rng_q   <= rng_data;
                  rng_req <= 1'b0;
                  state   <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               idx_q <= chk_idx;
               if (!chk_ok) begin
                  tries <= tries + 4'd1;
                  if (tries == LAST_TRY) begin
                     state <= ST_SCAN;
                  end else begin
                     state   <= ST_REQ;
                     rng_req <= 1'b1;
                  end
               end
            end
            ST_SCAN: begin
               if (!scan_ok) begin
                  idx_q <= next_idx(idx_q);
               end
            end
            ST_DEAL: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
         // The card is published on entry to DEAL so it lands at V+2.
         if (take) begin
            state         <= ST_DEAL;
            used[sel_idx] <= 1'b1;
            cards_left    <= cards_left - 6'd1;
            card_suit     <= dec_suit;
            card_rank     <= dec_rank;
            card_value    <= dec_value;
            card_valid    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer with a scripted RNG model.
// Expected cards are queued when the RNG answer is chosen.
module tb_card_dealer;

   logic       clk = 1'b0;
   logic       reset;
   logic       deal_req;
   logic       shuffle;
   logic       rng_req;
   logic       rng_valid;
   logic [5:0] rng_data;
   logic       card_valid;
   logic [1:0] card_suit;
   logic [3:0] card_rank;
   logic [3:0] card_value;
   logic [5:0] cards_left;
   logic       deck_empty;
   logic       busy;
   logic       deal_err;

   typedef struct {
      int suit;
      int rank;
      int value;
   } exp_t;

   exp_t sb[$];
   bit   m_used[52];
   int   m_left;
   int   n_checks = 0;
   int   n_fail   = 0;

   card_dealer #(.MAX_TRIES(8), .RNG_W(6)) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .deal_req   (deal_req),
      .shuffle    (shuffle),
      .rng_req    (rng_req),
      .rng_valid  (rng_valid),
      .rng_data   (rng_data),
      .card_valid (card_valid),
      .card_suit  (card_suit),
      .card_rank  (card_rank),
      .card_value (card_value),
      .cards_left (cards_left),
      .deck_empty (deck_empty),
      .busy       (busy),
      .deal_err   (deal_err)
   );

   always #10 clk = ~clk;

   function automatic exp_t mk(input int i);
      exp_t e;
      e.suit  = i / 13;
      e.rank  = i % 13 + 1;
      e.value = (e.rank > 10) ? 10 : e.rank;
      return e;
   endfunction

   function automatic int scan_from(input int v);
      int i;
      i = (v >= 52) ? v - 52 : v;
      for (int k = 0; k < 52; k++) begin
         if (!m_used[i]) return i;
         i = (i + 1) % 52;
      end
      return -1;
   endfunction

   function automatic void model_take(input int i);
      m_used[i] = 1'b1;
      m_left--;
      sb.push_back(mk(i));
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
      m_left = 52;
   endfunction

   task automatic rng_answer(input int val, input int delay);
      int t;
      t = 0;
      while (rng_req !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (rng_req !== 1'b1) begin
         n_fail++;
         $display("FAIL rng_req_wait: rng_req=%b required 1", rng_req);
      end
      repeat (delay) @(negedge clk);
      rng_valid = 1'b1;
      rng_data  = 6'(val);
      @(negedge clk);
      rng_valid = 1'b0;
      rng_data  = '0;
   endtask

   task automatic pulse_deal();
      deal_req = 1'b1;
      @(negedge clk);
      deal_req = 1'b0;
   endtask

   task automatic pulse_shuffle();
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      model_reset();
   endtask

   task automatic wait_card(output int lat, output bit rng_seen);
      lat      = 1;
      rng_seen = 1'b0;
      while (card_valid !== 1'b1 && lat < 300) begin
         @(negedge clk);
         if (rng_req === 1'b1) rng_seen = 1'b1;
         lat++;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      deal_req  = 1'b0;
      shuffle   = 1'b0;
      rng_valid = 1'b0;
      rng_data  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rng_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rng_req: got %b want 0", rng_req);
      end
      n_checks++;
      if (card_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_card_valid: got %b want 0", card_valid);
      end
      n_checks++;
      if (cards_left !== 6'd52) begin
         n_fail++;
         $display("FAIL reset_cards_left: got %0d want 52", cards_left);
      end
      n_checks++;
      if (deck_empty !== 1'b0 || busy !== 1'b0 || deal_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: empty=%b busy=%b err=%b want 0 0 0",
                  deck_empty, busy, deal_err);
      end
      n_checks++;
      if ({card_suit, card_rank, card_value} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_card: s=%0d r=%0d v=%0d want 0 0 0",
                  card_suit, card_rank, card_value);
      end
   endtask

   task automatic test_fast_path();
      int   lat;
      bit   rs;
      exp_t e;
      pulse_deal();
      n_checks++;
      if (rng_req !== 1'b1) begin
         n_fail++;
         $display("FAIL fast_rng_req_latency: got %b want 1", rng_req);
      end
      model_take(0);
      rng_answer(0, 3);
      wait_card(lat, rs);
      n_checks++;
      if (card_valid !== 1'b1 || lat != 2) begin
         n_fail++;
         $display("FAIL fast_latency: valid=%b lat=%0d want 1 2",
                  card_valid, lat);
      end
      e = sb.pop_front();
      n_checks++;
      if (card_suit !== 2'(e.suit) || card_rank !== 4'(e.rank) ||
          card_value !== 4'(e.value)) begin
         n_fail++;
         $display("FAIL fast_card: got %0d/%0d/%0d want %0d/%0d/%0d",
                  card_suit, card_rank, card_value, e.suit, e.rank, e.value);
      end
      n_checks++;
      if (cards_left !== 6'(m_left)) begin
         n_fail++;
         $display("FAIL fast_cards_left: got %0d want %0d", cards_left, m_left);
      end
      @(negedge clk);
      n_checks++;
      if (card_valid !== 1'b0 || busy !== 1'b0 || card_rank !== 4'(e.rank)) begin
         n_fail++;
         $display("FAIL fast_after: valid=%b busy=%b rank=%0d want 0 0 %0d",
                  card_valid, busy, card_rank, e.rank);
      end
   endtask

   task automatic test_reject();
      int   lat;
      bit   rs;
      exp_t e;
      pulse_deal();
      rng_answer(60, 1);
      @(negedge clk);
      n_checks++;
      if (rng_req !== 1'b1) begin
         n_fail++;
         $display("FAIL reject_rereq: got %b want 1", rng_req);
      end
      model_take(12);
      rng_answer(12, 0);
      wait_card(lat, rs);
      n_checks++;
      if (card_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reject_timeout: card_valid=%b want 1", card_valid);
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (card_suit !== 2'(e.suit) || card_rank !== 4'(e.rank) ||
             card_value !== 4'(e.value)) begin
            n_fail++;
            $display("FAIL reject_card: got %0d/%0d/%0d want %0d/%0d/%0d",
                     card_suit, card_rank, card_value, e.suit, e.rank, e.value);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_scan();
      int   lat;
      bit   rs;
      exp_t e;
      pulse_deal();
      for (int k = 0; k < 8; k++) rng_answer(0, 0);
      model_take(scan_from(0));
      wait_card(lat, rs);
      n_checks++;
      if (rs !== 1'b0) begin
         n_fail++;
         $display("FAIL scan_no_rng_req: rng_req seen=%b want 0", rs);
      end
      n_checks++;
      if (card_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL scan_timeout: card_valid=%b want 1", card_valid);
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (card_suit !== 2'(e.suit) || card_rank !== 4'(e.rank) ||
             card_value !== 4'(e.value)) begin
            n_fail++;
            $display("FAIL scan_card: got %0d/%0d/%0d want %0d/%0d/%0d",
                     card_suit, card_rank, card_value, e.suit, e.rank, e.value);
         end
      end
      n_checks++;
      if (cards_left !== 6'(m_left)) begin
         n_fail++;
         $display("FAIL scan_cards_left: got %0d want %0d", cards_left, m_left);
      end
      @(negedge clk);
   endtask

   task automatic test_full_deck();
      int   lat;
      int   v;
      int   key;
      bit   rs;
      bit   seen[52];
      exp_t e;
      pulse_shuffle();
      n_checks++;
      if (cards_left !== 6'd52) begin
         n_fail++;
         $display("FAIL deck_shuffle_left: got %0d want 52", cards_left);
      end
      for (int i = 0; i < 52; i++) seen[i] = 1'b0;
      for (int i = 0; i < 52; i++) begin
         v = (i * 7) % 52;
         pulse_deal();
         model_take(v);
         rng_answer(v, i % 3);
         wait_card(lat, rs);
         n_checks++;
         if (card_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL deck_timeout: deal %0d card_valid=%b want 1",
                     i, card_valid);
         end else begin
            e = sb.pop_front();
            n_checks++;
            if (card_suit !== 2'(e.suit) || card_rank !== 4'(e.rank) ||
                card_value !== 4'(e.value)) begin
               n_fail++;
               $display("FAIL deck_card: deal %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                        i, card_suit, card_rank, card_value,
                        e.suit, e.rank, e.value);
            end
            key = int'(card_suit) * 13 + int'(card_rank) - 1;
            n_checks++;
            if (key < 0 || key > 51 || seen[key]) begin
               n_fail++;
               $display("FAIL deck_unique: deal %0d key=%0d repeated or invalid, want fresh",
                        i, key);
            end else begin
               seen[key] = 1'b1;
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (deck_empty !== 1'b1 || cards_left !== 6'd0) begin
         n_fail++;
         $display("FAIL deck_empty: empty=%b left=%0d want 1 0",
                  deck_empty, cards_left);
      end
      pulse_deal();
      n_checks++;
      if (deal_err !== 1'b1 || rng_req !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL deal_err_pulse: err=%b req=%b busy=%b want 1 0 0",
                  deal_err, rng_req, busy);
      end
      @(negedge clk);
      n_checks++;
      if (deal_err !== 1'b0 || rng_req !== 1'b0) begin
         n_fail++;
         $display("FAIL deal_err_drop: err=%b req=%b want 0 0", deal_err, rng_req);
      end
   endtask

   task automatic test_shuffle_reset();
      int   lat;
      int   cv;
      bit   rs;
      exp_t e;
      pulse_shuffle();
      n_checks++;
      if ({card_suit, card_rank, card_value} !== 10'd0 || cards_left !== 6'd52) begin
         n_fail++;
         $display("FAIL shuffle_clear: card=%0d/%0d/%0d left=%0d want 0/0/0 52",
                  card_suit, card_rank, card_value, cards_left);
      end
      pulse_deal();
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      n_checks++;
      if (rng_req !== 1'b0 || cards_left !== 6'd52 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL shuffle_in_req: req=%b left=%0d busy=%b want 0 52 0",
                  rng_req, cards_left, busy);
      end
      cv = 0;
      repeat (5) begin
         rng_valid = 1'b1;
         rng_data  = 6'd3;
         @(negedge clk);
         if (card_valid === 1'b1) cv++;
      end
      rng_valid = 1'b0;
      n_checks++;
      if (cv != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL shuffle_no_card: card_valid count=%0d busy=%b want 0 0",
                  cv, busy);
      end
      deal_req = 1'b1;
      shuffle  = 1'b1;
      @(negedge clk);
      deal_req = 1'b0;
      shuffle  = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || rng_req !== 1'b0) begin
         n_fail++;
         $display("FAIL shuffle_wins: busy=%b req=%b want 0 0", busy, rng_req);
      end
      for (int i = 0; i < 6; i++) begin
         pulse_deal();
         model_take(i);
         rng_answer(i, 0);
         wait_card(lat, rs);
         n_checks++;
         if (card_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL prefill_timeout: deal %0d card_valid=%b want 1",
                     i, card_valid);
         end else begin
            e = sb.pop_front();
            n_checks++;
            if (card_rank !== 4'(e.rank) || card_suit !== 2'(e.suit)) begin
               n_fail++;
               $display("FAIL prefill_card: got %0d/%0d want %0d/%0d",
                        card_suit, card_rank, e.suit, e.rank);
            end
         end
         @(negedge clk);
      end
      pulse_deal();
      for (int k = 0; k < 8; k++) rng_answer(0, 0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || card_valid !== 1'b0 || rng_req !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_scan: busy=%b valid=%b req=%b want 1 0 0",
                  busy, card_valid, rng_req);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || rng_req !== 1'b0 || card_valid !== 1'b0 ||
          cards_left !== 6'd52 || deck_empty !== 1'b0 || deal_err !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_ctrl: busy=%b req=%b valid=%b left=%0d empty=%b err=%b",
                  busy, rng_req, card_valid, cards_left, deck_empty, deal_err);
      end
      n_checks++;
      if ({card_suit, card_rank, card_value} !== 10'd0) begin
         n_fail++;
         $display("FAIL async_reset_card: got %0d/%0d/%0d want 0/0/0",
                  card_suit, card_rank, card_value);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_fast_path();
      test_reject();
      test_scan();
      test_full_deck();
      test_shuffle_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
